dmem_mmio: RTL and testbench

- Data-side memory subsystem that consumes the single-cycle RV32I core's daddr/dwdata/dwe and returns drdata in the same cycle.
- Contains a byte-enabled word RAM and a small MMIO region.
- The MMIO region holds a free-running 64-bit cycle counter and a transmit byte FIFO, drained by an external consumer through a valid/ready handshake.

---
 rtl/dmem_mmio_if.sv | 24 ++
 rtl/dmem_mmio.sv | 128 ++++++++++++
 tb/tb_dmem_mmio.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_if.sv
// Data-side bus between the core (plus the TX byte consumer) and the
// data memory subsystem: word address/data/byte enables with a
// combinational read path, and the valid/ready TX byte stream.
interface dmem_mmio_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // Core and byte consumer side
    modport master (
        output daddr, dwdata, dwe, tx_ready,
        input  drdata, tx_data, tx_valid
    );

    // Memory subsystem side
    modport slave (
        input  daddr, dwdata, dwe, tx_ready,
        output drdata, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data memory subsystem for the single-cycle RV32I core: a byte-enabled
// word RAM with zero-latency reads, plus a small MMIO block holding a
// free-running 64-bit cycle counter and a transmit byte FIFO drained
// through a valid/ready handshake.
module dmem_mmio #(
    parameter int          RAM_AW    = 10,
    parameter int          FIFO_AW   = 3,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    dmem_mmio_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [31:0]        ram [0:(1<<RAM_AW)-1];
    logic [7:0]         fifo_mem [0:DEPTH-1];
    logic [RAM_AW-1:0]  ram_idx;
    logic [1:0]         reg_idx;
    logic               ram_sel;
    logic               mmio_sel;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   count;
    logic [7:0]         count8;
    logic               overflow;
    logic [63:0]        cycle_cnt;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push_req;
    logic               push_ok;
    logic               ovf_set;
    logic               ovf_clr;
    logic               unused_addr_bits;

    // Address decode: the low two address bits are lane offsets the core
    // has already folded into dwe/dwdata, so they play no part here.
    assign ram_sel  = (bus.daddr[31:RAM_AW+2] == '0);
    assign mmio_sel = (bus.daddr[31:4] == MMIO_BASE[31:4]);
    assign ram_idx  = bus.daddr[RAM_AW+1:2];
    assign reg_idx  = bus.daddr[3:2];
    assign unused_addr_bits = &{1'b0, bus.daddr[1:0]};

    // FIFO status and handshake. A push into a full FIFO still succeeds
    // when the head is leaving in the same cycle; otherwise it is dropped
    // and flagged as overflow.
    assign full     = (count == (FIFO_AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && bus.tx_ready;
    assign push_req = mmio_sel && (reg_idx == 2'd0) && bus.dwe[0];
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = mmio_sel && (reg_idx == 2'd1) && bus.dwe[0] && bus.dwdata[2];
    assign count8   = 8'(count);

    // The head byte is forced to zero while empty so the stream reads as
    // zero out of reset even though the storage array itself is not reset.
    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    // Combinational read mux; anything outside RAM and the register block reads as zero
    always_comb begin
        bus.drdata = '0;
        if (ram_sel) begin
            bus.drdata = ram[ram_idx];
        end else if (mmio_sel) begin
            case (reg_idx)
                2'd0:    bus.drdata = '0;
                2'd1:    bus.drdata = {16'h0000, count8, 5'b00000, overflow, empty, full};
                2'd2:    bus.drdata = cycle_cnt[31:0];
                default: bus.drdata = cycle_cnt[63:32];
            endcase
        end
    end

    // RAM byte-lane writes; contents survive reset, and a same-cycle read sees the old word
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_sel && bus.dwe[i]) begin
                ram[ram_idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
            end
        end
    end

    // FIFO storage write for accepted pushes only, so a dropped byte never disturbs queued data
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.dwdata[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag; reset empties the FIFO at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + (FIFO_AW+1)'(1);
            end else if (pop && !push_ok) begin
                count <= count - (FIFO_AW+1)'(1);
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Free-running cycle counter, wrapping silently at 2^64
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios with literal
// expectations followed by randomized bus traffic, all compared every
// cycle against a transaction-level model of RAM, FIFO and counter.
module tb_dmem_mmio;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam logic [31:0] A_TXDATA  = BASE + 32'h0;
    localparam logic [31:0] A_STATUS  = BASE + 32'h4;
    localparam logic [31:0] A_CYCLO   = BASE + 32'h8;
    localparam logic [31:0] A_CYCHI   = BASE + 32'hC;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dmem_mmio_if bus_if ();

    dmem_mmio #(
        .RAM_AW   (10),
        .FIFO_AW  (3),
        .MMIO_BASE(BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    // Reference model: RAM words with per-byte "written" flags, the FIFO as a queue
    bit [31:0]   ramM [0:1023];
    bit [3:0]    ramK [0:1023];
    byte unsigned fq[$];
    bit          ovM  = 1'b0;
    bit [63:0]   cycM = 64'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything ever stalls
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, actual, expected);
        end
    endtask

    // What a read of address a must return; m marks bits whose value is defined
    function automatic logic [31:0] modelRead(input logic [31:0] a, output logic [31:0] m);
        int n;
        n = fq.size();
        m = 32'hFFFF_FFFF;
        if (a[31:12] == 20'h0) begin
            for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{ramK[a[11:2]][i]}};
            return ramM[a[11:2]];
        end else if (a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0:    return 32'h0;
                2'd1:    return {16'h0, 8'(n), 5'h0, ovM, (n == 0), (n == 8)};
                2'd2:    return cycM[31:0];
                default: return cycM[63:32];
            endcase
        end
        return 32'h0;
    endfunction

    // Model state update at each clock edge, cleared the instant reset asserts
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
            ovM  = 1'b0;
            cycM = 64'd0;
        end else begin
            logic [31:0] a;
            logic        isMmio, pushReq, clrReq, popNow, wasFull;
            a       = bus_if.daddr;
            isMmio  = (a[31:4] == BASE[31:4]);
            pushReq = isMmio && (a[3:2] == 2'd0) && bus_if.dwe[0];
            clrReq  = isMmio && (a[3:2] == 2'd1) && bus_if.dwe[0] && bus_if.dwdata[2];
            popNow  = (fq.size() != 0) && bus_if.tx_ready;
            wasFull = (fq.size() == 8);
            if (a[31:12] == 20'h0) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus_if.dwe[i]) begin
                        ramM[a[11:2]][8*i +: 8] = bus_if.dwdata[8*i +: 8];
                        ramK[a[11:2]][i] = 1'b1;
                    end
                end
            end
            if (popNow) void'(fq.pop_front());
            if (pushReq) begin
                if (!wasFull || popNow) fq.push_back(bus_if.dwdata[7:0]);
                else ovM = 1'b1;
            end
            if (clrReq && !(pushReq && wasFull && !popNow)) ovM = 1'b0;
            cycM = cycM + 64'd1;
        end
    end

    // Every cycle, mid-period, the DUT outputs must match the model
    always @(negedge clk) begin
        logic [31:0] m, e;
        e = modelRead(bus_if.daddr, m);
        checkOutput("drdata", bus_if.drdata & m, e & m);
        checkOutput("tx_valid", 32'(bus_if.tx_valid), 32'(fq.size() != 0));
        checkOutput("tx_data", 32'(bus_if.tx_data), (fq.size() != 0) ? 32'(fq[0]) : 32'h0);
    end

    // One bus cycle: drive just after the edge, return mid-period with outputs settled
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic rdy);
        @(posedge clk);
        #1;
        bus_if.daddr    = a;
        bus_if.dwdata   = d;
        bus_if.dwe      = we;
        bus_if.tx_ready = rdy;
        @(negedge clk);
        #1;
    endtask

    task automatic readCheck(input string name, input logic [31:0] a, input logic rdy, input logic [31:0] exp);
        applyStimulus(a, 32'h0, 4'h0, rdy);
        checkOutput(name, bus_if.drdata, exp);
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0, 1, 2: return (32'($urandom_range(0, 15)) << 2) | lo;
            3, 4:    return A_TXDATA | lo;
            5:       return A_STATUS | lo;
            6:       return A_CYCLO | lo;
            7:       return A_CYCHI | lo;
            8:       return 32'h0000_1000 + (32'($urandom_range(0, 15)) << 2);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus_if.daddr    = A_STATUS;
        bus_if.dwdata   = 32'h0;
        bus_if.dwe      = 4'h0;
        bus_if.tx_ready = 1'b0;
        reset = 1'b0;

        // Values while held in reset
        repeat (2) @(posedge clk);
        #6;
        checkOutput("reset_tx_valid", 32'(bus_if.tx_valid), 32'h0);
        checkOutput("reset_tx_data", 32'(bus_if.tx_data), 32'h0);
        checkOutput("reset_status", bus_if.drdata, 32'h0000_0002);
        bus_if.daddr = A_CYCLO;
        #1;
        checkOutput("reset_cycle_lo", bus_if.drdata, 32'h0);
        bus_if.daddr = A_STATUS;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Cycle counter after exactly 100 edges out of reset
        repeat (99) applyStimulus(A_STATUS, 32'h0, 4'h0, 1'b0);
        readCheck("cycle_lo_100", A_CYCLO, 1'b0, 32'd100);
        readCheck("cycle_hi_0", A_CYCHI, 1'b0, 32'd0);

        // Byte-lane RAM writes and read-during-write
        applyStimulus(32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        applyStimulus(32'h14, 32'h1234_5678, 4'b1111, 1'b0);
        applyStimulus(32'h10, 32'h0000_5500, 4'b0010, 1'b0);
        readCheck("ram_lane_merge", 32'h10, 1'b0, 32'hDEAD_55EF);
        readCheck("ram_neighbour", 32'h14, 1'b0, 32'h1234_5678);
        applyStimulus(32'h18, 32'h1111_1111, 4'b1111, 1'b0);
        applyStimulus(32'h18, 32'h2222_2222, 4'b1111, 1'b0);
        checkOutput("ram_rdw_old", bus_if.drdata, 32'h1111_1111);
        readCheck("ram_rdw_new", 32'h18, 1'b0, 32'h2222_2222);

        // Overfill: nine pushes into eight slots, then drain in order
        for (int i = 1; i <= 9; i++) applyStimulus(A_TXDATA, 32'(i), 4'b0001, 1'b0);
        readCheck("status_overflow", A_STATUS, 1'b0, 32'h0000_0805);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(A_STATUS, 32'h0, 4'h0, 1'b1);
            checkOutput("drain_order", {23'h0, bus_if.tx_valid, bus_if.tx_data}, 32'h100 | 32'(i));
        end
        applyStimulus(A_STATUS, 32'h0, 4'h0, 1'b1);
        checkOutput("drain_empty", 32'(bus_if.tx_valid), 32'h0);

        // Clearing overflow through STATUS
        applyStimulus(A_STATUS, 32'h0000_0004, 4'b0001, 1'b0);
        readCheck("status_cleared", A_STATUS, 1'b0, 32'h0000_0002);

        // Push into a full FIFO while the head leaves: accepted, no overflow
        for (int i = 0; i < 8; i++) applyStimulus(A_TXDATA, 32'h11 + 32'(i), 4'b0001, 1'b0);
        applyStimulus(A_TXDATA, 32'h0000_00AA, 4'b0001, 1'b1);
        readCheck("status_full_pushpop", A_STATUS, 1'b0, 32'h0000_0801);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(A_STATUS, 32'h0, 4'h0, 1'b1);
            checkOutput("pushpop_order", 32'(bus_if.tx_data), (i == 7) ? 32'hAA : 32'h12 + 32'(i));
        end

        // Unmapped addresses read zero and never alias into RAM
        applyStimulus(32'h0, 32'hCAFE_F00D, 4'b1111, 1'b0);
        applyStimulus(32'h0000_1000, 32'h5A5A_5A5A, 4'b1111, 1'b0);
        applyStimulus(32'h9000_0000, 32'hA5A5_A5A5, 4'b1111, 1'b0);
        readCheck("unmapped_9000", 32'h9000_0000, 1'b0, 32'h0);
        readCheck("unmapped_1000", 32'h0000_1000, 1'b0, 32'h0);
        readCheck("ram_no_alias", 32'h0, 1'b0, 32'hCAFE_F00D);

        // Asynchronous reset in the middle of a cycle with bytes queued
        for (int i = 0; i < 3; i++) applyStimulus(A_TXDATA, 32'h40 + 32'(i), 4'b0001, 1'b0);
        applyStimulus(A_STATUS, 32'h0, 4'h0, 1'b0);
        checkOutput("pre_reset_valid", 32'(bus_if.tx_valid), 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(bus_if.tx_valid), 32'h0);
        checkOutput("async_reset_data", 32'(bus_if.tx_data), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        readCheck("status_after_reset", A_STATUS, 1'b0, 32'h0000_0002);
        readCheck("cycle_after_reset", A_CYCLO, 1'b0, 32'd2);

        // Randomized traffic, checked by the per-cycle comparison
        for (int n = 0; n < 800; n++) begin
            logic [3:0] we;
            we = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            applyStimulus(randAddr(), $urandom, we, 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
